ball_move_checker: RTL and testbench

- Downstream of the ball position stage: takes each proposed ball coordinate, looks it up in the maze map ROM and commits only legal moves.
- Drives the final ball coordinates consumed by the display/game logic.
- Applies the map rules:
  - walls block movement;
  - diagonal moves slide along walls;
  - holes send the ball back to start;
  - the goal latches a win flag.

---
 rtl/ball_move_checker_if.sv | 23 ++
 rtl/ball_move_checker.sv | 144 ++++++++++++++
 tb/tb_ball_move_checker.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_move_checker_if.sv
// Request/ROM bundle between the ball position stage, the maze map ROM and the move checker.
// The checker sits on the slave side; the upstream stage and the ROM together form the master side.
interface ball_move_checker_if #(
    parameter int COORD_WIDTH = 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic [COORD_WIDTH-1:0] req_x;
    logic [COORD_WIDTH-1:0] req_y;
    logic                   map_rd_en;
    logic [7:0]             map_addr;
    logic [1:0]             map_data;

    modport master (
        output req_valid, req_x, req_y, map_data,
        input  req_ready, map_rd_en, map_addr
    );

    modport slave (
        input  req_valid, req_x, req_y, map_data,
        output req_ready, map_rd_en, map_addr
    );
endinterface

// File: rtl/ball_move_checker.sv
// Validates proposed ball moves against the maze map ROM and commits only legal ones.
// It handles walls with wall sliding for diagonals, respawns on holes, and latches a sticky goal flag.
module ball_move_checker #(
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 16,
    parameter int COORD_WIDTH = 8,
    parameter int START_X     = 0,
    parameter int START_Y     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    ball_move_checker_if.slave     bus,
    output logic [COORD_WIDTH-1:0] x_out,
    output logic [COORD_WIDTH-1:0] y_out,
    output logic                   pos_valid,
    output logic                   blocked,
    output logic                   hole_hit,
    output logic                   goal_reached
);

    localparam logic [COORD_WIDTH-1:0] GRID_W_C  = COORD_WIDTH'(GRID_W);
    localparam logic [COORD_WIDTH-1:0] GRID_H_C  = COORD_WIDTH'(GRID_H);
    localparam logic [COORD_WIDTH-1:0] START_X_C = COORD_WIDTH'(START_X);
    localparam logic [COORD_WIDTH-1:0] START_Y_C = COORD_WIDTH'(START_Y);

    localparam logic [1:0] CELL_OPEN = 2'b00;
    localparam logic [1:0] CELL_GOAL = 2'b01;
    localparam logic [1:0] CELL_WALL = 2'b10;
    localparam logic [1:0] CELL_HOLE = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, EVAL, COMMIT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [COORD_WIDTH-1:0] req_x_q;
    logic [COORD_WIDTH-1:0] req_y_q;
    logic [1:0]             cand_idx;
    logic [1:0]             last_idx;
    logic [COORD_WIDTH-1:0] cand_x;
    logic [COORD_WIDTH-1:0] cand_y;
    logic                   in_bounds;
    logic                   same_pos;
    logic                   is_diag;
    logic                   accept_move;
    logic                   is_wall;
    logic                   more_cands;

    assign in_bounds   = (bus.req_x < GRID_W_C) && (bus.req_y < GRID_H_C);
    assign same_pos    = (bus.req_x == x_out) && (bus.req_y == y_out);
    assign is_diag     = (bus.req_x != x_out) && (bus.req_y != y_out);
    assign accept_move = bus.req_valid && in_bounds && !same_pos && !goal_reached;
    assign is_wall     = (bus.map_data == CELL_WALL);
    assign more_cands  = (cand_idx != last_idx);

    // The committed position is frozen during a lookup, so the slide candidates
    // (req_x, y_out) and (x_out, req_y) can be formed on the fly from the index.
    assign cand_x = (cand_idx == 2'd2) ? x_out : req_x_q;
    assign cand_y = (cand_idx == 2'd1) ? y_out : req_y_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_move) state_next = READ;
            READ:    state_next = EVAL;
            EVAL: begin
                if (!is_wall)        state_next = COMMIT;
                else if (more_cands) state_next = READ;
                else                 state_next = IDLE;
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.map_rd_en = (state == READ);
        bus.map_addr  = 8'd0;
        if (state == READ) begin
            bus.map_addr = {cand_y[3:0], cand_x[3:0]};
        end
    end

    // Position and pulses are registered on the EVAL edge so they appear while in COMMIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_out        <= START_X_C;
            y_out        <= START_Y_C;
            pos_valid    <= 1'b0;
            blocked      <= 1'b0;
            hole_hit     <= 1'b0;
            goal_reached <= 1'b0;
            req_x_q      <= '0;
            req_y_q      <= '0;
            cand_idx     <= 2'd0;
            last_idx     <= 2'd0;
        end else begin
            pos_valid <= 1'b0;
            blocked   <= 1'b0;
            hole_hit  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && !in_bounds) begin
                        blocked <= 1'b1;
                    end else if (accept_move) begin
                        req_x_q  <= bus.req_x;
                        req_y_q  <= bus.req_y;
                        cand_idx <= 2'd0;
                        last_idx <= is_diag ? 2'd2 : 2'd0;
                    end
                end
                EVAL: begin
                    if (is_wall) begin
                        if (more_cands) cand_idx <= cand_idx + 2'd1;
                        else            blocked  <= 1'b1;
                    end else if (bus.map_data == CELL_HOLE) begin
                        x_out     <= START_X_C;
                        y_out     <= START_Y_C;
                        pos_valid <= 1'b1;
                        hole_hit  <= 1'b1;
                    end else begin
                        x_out     <= cand_x;
                        y_out     <= cand_y;
                        pos_valid <= 1'b1;
                        if (bus.map_data == CELL_GOAL) goal_reached <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic unused_open;
    assign unused_open = (CELL_OPEN == 2'b00);

endmodule

// File: tb/tb_ball_move_checker.sv
// Randomized self-checking bench for ball_move_checker against a list-based model of the map rules.
// The directed test-plan moves run first, followed by random moves over a random maze.
module tb_ball_move_checker;

    localparam int GRID_W  = 16;
    localparam int GRID_H  = 16;
    localparam int CW      = 8;
    localparam int START_X = 0;
    localparam int START_Y = 0;

    localparam logic [1:0] OPEN = 2'b00;
    localparam logic [1:0] GOAL = 2'b01;
    localparam logic [1:0] WALL = 2'b10;
    localparam logic [1:0] HOLE = 2'b11;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ball_move_checker_if #(.COORD_WIDTH(CW)) bus();
    logic [CW-1:0] x_out;
    logic [CW-1:0] y_out;
    logic          pos_valid;
    logic          blocked;
    logic          hole_hit;
    logic          goal_reached;

    ball_move_checker #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .COORD_WIDTH(CW), .START_X(START_X), .START_Y(START_Y)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .x_out(x_out), .y_out(y_out), .pos_valid(pos_valid),
        .blocked(blocked), .hole_hit(hole_hit), .goal_reached(goal_reached)
    );

    // Maze ROM: data is valid only in the cycle after a read strobe.
    logic [1:0] rom [256];
    always @(posedge clk) bus.map_data <= bus.map_rd_en ? rom[bus.map_addr] : 2'b00;

    int n_checks = 0;
    int n_fail   = 0;

    int mx, my;
    bit mgoal;
    int exp_reads[$], exp_read_cyc[$];
    int exp_pv, exp_blk, exp_hole, exp_evt_cyc, exp_ready_cyc;

    int obs_reads[$], obs_read_cyc[$];
    int obs_pv, obs_blk, obs_hole, obs_evt_first, obs_evt_last, obs_ready_cyc;
    int obs_x, obs_y;
    logic obs_ready0, obs_goal;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mx = START_X;
        my = START_Y;
        mgoal = 1'b0;
    endtask

    // Cycle numbers count the acceptance edge as clock 0.
    task automatic model_move(input int x, input int y);
        int cxq[$], cyq[$];
        bit done;
        exp_reads.delete();
        exp_read_cyc.delete();
        exp_pv = 0; exp_blk = 0; exp_hole = 0; exp_evt_cyc = 0; exp_ready_cyc = 1;
        if (x >= GRID_W || y >= GRID_H) begin
            exp_blk = 1;
            exp_evt_cyc = 1;
        end else if (!((x == mx && y == my) || mgoal)) begin
            cxq.push_back(x); cyq.push_back(y);
            if (x != mx && y != my) begin
                cxq.push_back(x);  cyq.push_back(my);
                cxq.push_back(mx); cyq.push_back(y);
            end
            done = 1'b0;
            for (int k = 0; k < cxq.size() && !done; k++) begin
                int a;
                a = cyq[k] * 16 + cxq[k];
                exp_reads.push_back(a);
                exp_read_cyc.push_back(1 + 2 * k);
                if (rom[a] != WALL) begin
                    done = 1'b1;
                    exp_pv = 1;
                    exp_evt_cyc = 3 + 2 * k;
                    exp_ready_cyc = 4 + 2 * k;
                    if (rom[a] == HOLE) begin
                        exp_hole = 1;
                        mx = START_X;
                        my = START_Y;
                    end else begin
                        mx = cxq[k];
                        my = cyq[k];
                        if (rom[a] == GOAL) mgoal = 1'b1;
                    end
                end
            end
            if (!done) begin
                exp_blk = 1;
                exp_evt_cyc = 2 * cxq.size() + 1;
                exp_ready_cyc = exp_evt_cyc;
            end
        end
    endtask

    task automatic run_move(input int x, input int y);
        obs_reads.delete();
        obs_read_cyc.delete();
        obs_pv = 0; obs_blk = 0; obs_hole = 0;
        obs_evt_first = 0; obs_evt_last = 0; obs_ready_cyc = 0;
        @(negedge clk);
        obs_ready0 = bus.req_ready;
        bus.req_valid = 1'b1;
        bus.req_x = CW'(x);
        bus.req_y = CW'(y);
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (bus.map_rd_en) begin
                obs_reads.push_back(int'(bus.map_addr));
                obs_read_cyc.push_back(c);
            end
            if (pos_valid) obs_pv++;
            if (blocked)   obs_blk++;
            if (hole_hit)  obs_hole++;
            if (pos_valid || blocked || hole_hit) begin
                if (obs_evt_first == 0) obs_evt_first = c;
                obs_evt_last = c;
            end
            if (bus.req_ready && obs_ready_cyc == 0) obs_ready_cyc = c;
            if (c == 1) bus.req_valid = 1'b0;
        end
        obs_x = int'(x_out);
        obs_y = int'(y_out);
        obs_goal = goal_reached;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        mx = START_X; my = START_Y; mgoal = 1'b0;
        n_checks++; if (x_out !== CW'(START_X)) begin n_fail++; $display("[TB] FAIL reset_x: got %0d expected %0d", x_out, START_X); end
        n_checks++; if (y_out !== CW'(START_Y)) begin n_fail++; $display("[TB] FAIL reset_y: got %0d expected %0d", y_out, START_Y); end
        n_checks++; if ({pos_valid, blocked, hole_hit, goal_reached} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", {pos_valid, blocked, hole_hit, goal_reached}); end
        n_checks++; if (bus.map_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_en: got %b expected 0", bus.map_rd_en); end
        n_checks++; if (bus.map_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 00", bus.map_addr); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_moves(input int n_random);
        int rx, ry, r;
        bit reset_after;
        for (int i = 0; i < 9 + n_random; i++) begin
            reset_after = mgoal;
            if (i == 0) for (int a = 0; a < 256; a++) rom[a] = OPEN;
            case (i)
                0: begin rx = 1; ry = 0; end
                1: begin rom[8'h02] = WALL; rx = 2; ry = 0; end
                2: begin rx = 2; ry = 2; end
                3: begin rom[8'h33] = WALL; rom[8'h23] = OPEN; rx = 3; ry = 3; end
                4: begin rx = 2; ry = 2; end
                5: begin rom[8'h23] = WALL; rom[8'h32] = WALL; rx = 3; ry = 3; end
                6: begin rom[8'h12] = HOLE; rx = 2; ry = 1; end
                7: begin rx = 16; ry = 0; end
                8: begin rx = 0; ry = 0; end
                default: begin
                    if (i == 9) begin
                        for (int a = 0; a < 256; a++) begin
                            r = int'($urandom_range(0, 99));
                            rom[a] = (r < 60) ? OPEN : (r < 85) ? WALL : (r < 95) ? HOLE : GOAL;
                        end
                    end
                    r = int'($urandom_range(0, 9));
                    if (r < 6) begin
                        rx = (mx + 255 + int'($urandom_range(0, 2))) % 256;
                        ry = (my + 255 + int'($urandom_range(0, 2))) % 256;
                    end else if (r < 7) begin
                        rx = int'($urandom_range(16, 255));
                        ry = int'($urandom_range(0, 20));
                    end else begin
                        rx = int'($urandom_range(0, 15));
                        ry = int'($urandom_range(0, 15));
                    end
                end
            endcase
            model_move(rx, ry);
            run_move(rx, ry);
            n_checks++; if (obs_ready0 !== 1'b1) begin n_fail++; $display("[TB] FAIL move%0d_ready_in: got %b expected 1", i, obs_ready0); end
            n_checks++; if (obs_pv != exp_pv) begin n_fail++; $display("[TB] FAIL move%0d_pos_valid_count: got %0d expected %0d", i, obs_pv, exp_pv); end
            n_checks++; if (obs_blk != exp_blk) begin n_fail++; $display("[TB] FAIL move%0d_blocked_count: got %0d expected %0d", i, obs_blk, exp_blk); end
            n_checks++; if (obs_hole != exp_hole) begin n_fail++; $display("[TB] FAIL move%0d_hole_count: got %0d expected %0d", i, obs_hole, exp_hole); end
            n_checks++; if (obs_evt_first != exp_evt_cyc || obs_evt_last != exp_evt_cyc) begin n_fail++; $display("[TB] FAIL move%0d_pulse_cycle: got %0d..%0d expected %0d", i, obs_evt_first, obs_evt_last, exp_evt_cyc); end
            n_checks++; if (obs_ready_cyc != exp_ready_cyc) begin n_fail++; $display("[TB] FAIL move%0d_ready_return: got cycle %0d expected %0d", i, obs_ready_cyc, exp_ready_cyc); end
            n_checks++; if (obs_reads.size() != exp_reads.size()) begin n_fail++; $display("[TB] FAIL move%0d_read_count: got %0d expected %0d", i, obs_reads.size(), exp_reads.size()); end
            for (int k = 0; k < obs_reads.size() && k < exp_reads.size(); k++) begin
                n_checks++; if (obs_reads[k] != exp_reads[k] || obs_read_cyc[k] != exp_read_cyc[k]) begin n_fail++; $display("[TB] FAIL move%0d_read%0d: got %h@%0d expected %h@%0d", i, k, obs_reads[k], obs_read_cyc[k], exp_reads[k], exp_read_cyc[k]); end
            end
            n_checks++; if (obs_x != mx || obs_y != my) begin n_fail++; $display("[TB] FAIL move%0d_position: got (%0d,%0d) expected (%0d,%0d)", i, obs_x, obs_y, mx, my); end
            n_checks++; if (obs_goal !== mgoal) begin n_fail++; $display("[TB] FAIL move%0d_goal: got %b expected %b", i, obs_goal, mgoal); end
            if (reset_after) apply_reset();
        end
    endtask

    task automatic test_goal();
        apply_reset();
        for (int a = 0; a < 256; a++) rom[a] = OPEN;
        rom[8'h10] = GOAL;
        model_move(0, 1);
        run_move(0, 1);
        n_checks++; if (obs_goal !== 1'b1) begin n_fail++; $display("[TB] FAIL goal_set: got %b expected 1", obs_goal); end
        n_checks++; if (obs_x != 0 || obs_y != 1) begin n_fail++; $display("[TB] FAIL goal_position: got (%0d,%0d) expected (0,1)", obs_x, obs_y); end
        n_checks++; if (obs_pv != 1) begin n_fail++; $display("[TB] FAIL goal_pos_valid: got %0d expected 1", obs_pv); end
        model_move(5, 5);
        run_move(5, 5);
        n_checks++; if (obs_reads.size() != 0) begin n_fail++; $display("[TB] FAIL goal_drop_reads: got %0d expected 0", obs_reads.size()); end
        n_checks++; if (obs_pv + obs_blk + obs_hole != 0) begin n_fail++; $display("[TB] FAIL goal_drop_pulses: got %0d expected 0", obs_pv + obs_blk + obs_hole); end
        n_checks++; if (obs_x != 0 || obs_y != 1 || obs_goal !== 1'b1) begin n_fail++; $display("[TB] FAIL goal_drop_state: got (%0d,%0d) goal %b expected (0,1) goal 1", obs_x, obs_y, obs_goal); end
        apply_reset();
        n_checks++; if (goal_reached !== 1'b0) begin n_fail++; $display("[TB] FAIL goal_cleared_by_reset: got %b expected 0", goal_reached); end
    endtask

    task automatic test_mid_reset();
        int pulses;
        apply_reset();
        for (int a = 0; a < 256; a++) rom[a] = OPEN;
        model_move(1, 0);
        run_move(1, 0);
        n_checks++; if (obs_x != 1 || obs_y != 0) begin n_fail++; $display("[TB] FAIL premove_position: got (%0d,%0d) expected (1,0)", obs_x, obs_y); end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_x = 8'd2;
        bus.req_y = 8'd0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.map_rd_en !== 1'b1 || bus.map_addr !== 8'h02) begin n_fail++; $display("[TB] FAIL mid_read: got en %b addr %h expected en 1 addr 02", bus.map_rd_en, bus.map_addr); end
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mx = START_X; my = START_Y; mgoal = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (pos_valid || blocked || hole_hit || bus.map_rd_en) pulses++;
            @(negedge clk);
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("[TB] FAIL mid_reset_activity: got %0d expected 0", pulses); end
        n_checks++; if (x_out !== CW'(START_X) || y_out !== CW'(START_Y)) begin n_fail++; $display("[TB] FAIL mid_reset_position: got (%0d,%0d) expected (%0d,%0d)", x_out, y_out, START_X, START_Y); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", bus.req_ready); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_x = '0;
        bus.req_y = '0;
        $display("[TB] starting ball_move_checker bench");
        test_reset();
        test_moves(200);
        test_goal();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
